// File: rtl/sensor_err_monitor_if.sv
// sensor_err_monitor_if: sensor inputs, clear and fault outputs of the error monitor.
// SENSOR_MASK_EN adds the per-sensor mask signal.
interface sensor_err_monitor_if #(
  parameter int NUM_SENS = 4,
  parameter int CNT_W    = 8
);
  logic [NUM_SENS-1:0] sensors;
`ifdef SENSOR_MASK_EN
  logic [NUM_SENS-1:0] mask;
`endif
  logic                clear;
  logic                error;
  logic                error_latched;
  logic [CNT_W-1:0]    error_cnt;
  modport master (
    output sensors, clear,
`ifdef SENSOR_MASK_EN
    output mask,
`endif
    input  error, error_latched, error_cnt
  );
  modport slave (
    input  sensors, clear,
`ifdef SENSOR_MASK_EN
    input  mask,
`endif
    output error, error_latched, error_cnt
  );
endinterface

// File: rtl/sensor_err_monitor.sv
// sensor_err_monitor: debounced sensor fault detector with sticky flag and saturating onset count.
// SENSOR_MASK_EN adds a mask that removes sensors from the fault rule.
module sensor_err_monitor #(
  parameter int NUM_SENS   = 4,
  parameter int DEB_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input logic                clk,
  input logic                rst,
  sensor_err_monitor_if.slave bus
);
  localparam int KW = $clog2(DEB_CYCLES + 1);
  localparam logic [KW-1:0] K_MAX = KW'(DEB_CYCLES);
  typedef enum logic [1:0] {IDLE, QUAL, FAULT, RECOVER} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, k_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic error_q, error_d, latched_q, latched_d;
  logic [NUM_SENS-1:0] eff;
  logic raw, onset;
`ifdef SENSOR_MASK_EN
  assign eff = bus.sensors & ~bus.mask;
`else
  assign eff = bus.sensors;
`endif
  assign raw   = eff[0] | (eff[1] & |eff[NUM_SENS-1:2]);
  assign k_inc = k_q + 1'b1;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    onset   = 1'b0;
    case (state_q)
      IDLE:
        if (raw) begin
          state_d = (DEB_CYCLES == 1) ? FAULT : QUAL;
          k_d     = (DEB_CYCLES == 1) ? '0 : KW'(1);
          onset   = (DEB_CYCLES == 1);
        end
      QUAL: begin
        state_d = !raw ? IDLE : (k_inc == K_MAX) ? FAULT : QUAL;
        k_d     = (!raw || k_inc == K_MAX) ? '0 : k_inc;
        onset   = raw && k_inc == K_MAX;
      end
      FAULT:
        if (!raw) begin
          state_d = (DEB_CYCLES == 1) ? IDLE : RECOVER;
          k_d     = (DEB_CYCLES == 1) ? '0 : KW'(1);
        end
      default: begin
        state_d = raw ? FAULT : (k_inc == K_MAX) ? IDLE : RECOVER;
        k_d     = (raw || k_inc == K_MAX) ? '0 : k_inc;
      end
    endcase
    error_d   = (state_d == FAULT) || (state_d == RECOVER);
    latched_d = onset | (latched_q & ~bus.clear);
    // an onset beats a coincident clear, restarting the count at 1
    cnt_d     = onset ? (bus.clear ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1))
                      : (bus.clear ? '0 : cnt_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      error_q   <= 1'b0;
      latched_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      error_q   <= error_d;
      latched_q <= latched_d;
      cnt_q     <= cnt_d;
    end
  assign bus.error         = error_q;
  assign bus.error_latched = latched_q;
  assign bus.error_cnt     = cnt_q;
endmodule

// File: tb/tb_sensor_err_monitor.sv
// tb_sensor_err_monitor: directed vectors for the debounced monitor (NUM_SENS=4, DEB_CYCLES=3, CNT_W=2).
// Build with SENSOR_MASK_EN to exercise the mask.
module tb_sensor_err_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  sensor_err_monitor_if #(.NUM_SENS(4), .CNT_W(2)) bus ();
  sensor_err_monitor #(.NUM_SENS(4), .DEB_CYCLES(3), .CNT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input int e, input int l, input int c);
    check({tag, ".error"}, int'(bus.error), e);
    check({tag, ".latched"}, int'(bus.error_latched), l);
    check({tag, ".cnt"}, int'(bus.error_cnt), c);
  endtask
  initial begin
    bus.sensors = 4'b0001;
    bus.clear   = 1'b0;
`ifdef SENSOR_MASK_EN
    bus.mask    = 4'b0000;
`endif
    step(5);
    outs("rst_hold", 0, 0, 0);
    rst = 1'b0;
    step(2);
    check("rst_rel_2", int'(bus.error), 0);
    step(1);
    outs("rst_rel_3", 1, 1, 1);
    rst = 1'b1;
    #2;
    outs("async_rst", 0, 0, 0);
    bus.sensors = 4'b0000;
    step(1);
    rst = 1'b0;
    bus.sensors = 4'b0001;
    step(2);
    bus.sensors = 4'b0000;
    step(1);
    check("short_burst", int'(bus.error), 0);
    bus.sensors = 4'b0001;
    step(2);
    check("qual_2", int'(bus.error), 0);
    step(1);
    outs("qual_3", 1, 1, 1);
    bus.sensors = 4'b0000;
    step(2);
    check("rec_2", int'(bus.error), 1);
    bus.sensors = 4'b0001;
    step(1);
    check("rec_glitch", int'(bus.error), 1);
    bus.sensors = 4'b0000;
    step(2);
    check("rec_again_2", int'(bus.error), 1);
    step(1);
    outs("rec_done", 0, 1, 1);
    bus.sensors = 4'b1010;
    step(3);
    outs("pair_1010", 1, 1, 2);
    bus.sensors = 4'b0000;
    step(3);
    check("pair_clear", int'(bus.error), 0);
    bus.sensors = 4'b0010;
    step(10);
    check("only_s1", int'(bus.error), 0);
    bus.sensors = 4'b1100;
    step(10);
    outs("no_s1", 0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      bus.sensors = 4'b0001;
      step(3);
      bus.sensors = 4'b0000;
      step(3);
    end
    outs("saturate", 0, 1, 3);
    bus.sensors = 4'b0001;
    step(3);
    check("sat_hold", int'(bus.error_cnt), 3);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    outs("clear_in_fault", 1, 0, 0);
    bus.sensors = 4'b0000;
    step(3);
    check("clear_exit", int'(bus.error), 0);
    bus.sensors = 4'b0001;
    step(2);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    outs("clear_vs_onset", 1, 1, 1);
    bus.sensors = 4'b0000;
    step(3);
    check("idle_again", int'(bus.error), 0);
`ifdef SENSOR_MASK_EN
    bus.mask    = 4'b0001;
    bus.sensors = 4'b0001;
    step(5);
    check("masked", int'(bus.error), 0);
    bus.mask = 4'b0000;
    step(2);
    check("unmask_2", int'(bus.error), 0);
    step(1);
    check("unmask_3", int'(bus.error), 1);
`else
    bus.sensors = 4'b0001;
    step(2);
    check("nomask_2", int'(bus.error), 0);
    step(1);
    check("nomask_3", int'(bus.error), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
